// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end for a small big-endian, word-organised data memory.
// Accepts one request at a time, checks alignment/size/range, performs
// sub-word loads with sign/zero extension and sub-word stores through a
// read-modify-write, so the memory only ever sees aligned word accesses.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge) and asynchronous active-low reset
//   req_valid_i/ready_o  request handshake; accepted when both are high
//   req_write_i          1 = store, 0 = load
//   req_size_i           0 byte, 1 halfword, 2 word, 3 illegal
//   req_signed_i         loads: sign-extend when set, else zero-extend
//   req_addr_i           byte address
//   req_wdata_i          right-justified store data
//   resp_valid_o         one-cycle completion pulse
//   resp_err_o           error flag, meaningful with resp_valid_o
//   resp_rdata_o         load result with resp_valid_o, 0 for stores/errors
//   dm_addr_o            word-aligned memory address (registered)
//   dm_wdata_o           memory write data (registered)
//   dm_write_o           memory write enable, high only in the WRITE state
//   dm_rdata_i           combinational memory read data, byte 0 in [31:24]
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic        dm_write_o,
    input  logic [31:0] dm_rdata_i
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        accept;
    logic        req_err;

    // Pick the addressed lane out of a big-endian word and extend it.
    function automatic logic [31:0] extractLane(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'd0:    res = {{24{sgn & b[7]}}, b};
            2'd1:    res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overwrite the addressed lane of the old word with the store data.
    function automatic logic [31:0] mergeLane(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
        logic [31:0] res;
        res = word;
        if (size == 2'd0) begin
            case (off)
                2'd0:    res[31:24] = data[7:0];
                2'd1:    res[23:16] = data[7:0];
                2'd2:    res[15:8]  = data[7:0];
                default: res[7:0]   = data[7:0];
            endcase
        end else if (size == 2'd1) begin
            if (off[1]) res[15:0]  = data[15:0];
            else        res[31:16] = data[15:0];
        end
        return res;
    endfunction

    assign accept = (state_q == IDLE) && req_valid_i;

    // Full 32-bit range compare so addresses near 2^32 cannot wrap into range.
    assign req_err = (req_size_i == 2'd3)
                   || ((req_size_i == 2'd1) && req_addr_i[0])
                   || ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00))
                   || (req_addr_i >= 32'(MEM_BYTES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            off_q      <= 2'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            dm_addr_q  <= 32'd0;
            dm_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            off_q      <= off_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_err)                 state_d = RESP;
                    else if (!req_write_i)       state_d = LOAD;
                    else if (req_size_i == 2'd2) state_d = WRITE;
                    else                         state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // dm_wdata doubles as the latched store data until the RMW merge.
    always_comb begin
        size_d     = size_q;
        signed_d   = signed_q;
        off_d      = off_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        if (accept) begin
            size_d     = req_size_i;
            signed_d   = req_signed_i;
            off_d      = req_addr_i[1:0];
            err_d      = req_err;
            rdata_d    = 32'd0;
            dm_addr_d  = {req_addr_i[31:2], 2'b00};
            dm_wdata_d = req_wdata_i;
        end else if (state_q == LOAD) begin
            rdata_d = extractLane(dm_rdata_i, size_q, off_q, signed_q);
        end else if (state_q == RMW_RD) begin
            dm_wdata_d = mergeLane(dm_rdata_i, dm_wdata_q, size_q, off_q);
        end
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
        resp_err_o   = (state_q == RESP) && err_q;
        resp_rdata_o = (state_q == RESP) ? rdata_q : 32'd0;
        dm_write_o   = (state_q == WRITE);
        dm_addr_o    = dm_addr_q;
        dm_wdata_o   = dm_wdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit with a behavioural
// 32-byte big-endian memory (combinational read, falling-edge write).
module tb_mem_access_unit;

   logic        clk;
   logic        rstN;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [1:0]  reqSize;
   logic        reqSigned;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        respValid;
   logic        respErr;
   logic [31:0] respRdata;
   logic [31:0] dmAddr;
   logic [31:0] dmWdata;
   logic        dmWrite;
   logic [31:0] dmRdata;

   logic [7:0]  mem [0:31];

   int numChecks = 0;
   int numPassed = 0;
   int numFailed = 0;

   mem_access_unit #(.MEM_BYTES(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_write_i  (reqWrite),
      .req_size_i   (reqSize),
      .req_signed_i (reqSigned),
      .req_addr_i   (reqAddr),
      .req_wdata_i  (reqWdata),
      .resp_valid_o (respValid),
      .resp_err_o   (respErr),
      .resp_rdata_o (respRdata),
      .dm_addr_o    (dmAddr),
      .dm_wdata_o   (dmWdata),
      .dm_write_o   (dmWrite),
      .dm_rdata_i   (dmRdata)
   );

   // Free-running clock, rising edge active.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational big-endian read of the addressed word.
   assign dmRdata = {mem[{dmAddr[4:2], 2'b00}], mem[{dmAddr[4:2], 2'b01}],
                     mem[{dmAddr[4:2], 2'b10}], mem[{dmAddr[4:2], 2'b11}]};

   // Memory model: write lands on the falling edge inside the WRITE cycle.
   always @(negedge clk) begin
      if (dmWrite) begin
         mem[{dmAddr[4:2], 2'b00}] <= dmWdata[31:24];
         mem[{dmAddr[4:2], 2'b01}] <= dmWdata[23:16];
         mem[{dmAddr[4:2], 2'b10}] <= dmWdata[15:8];
         mem[{dmAddr[4:2], 2'b11}] <= dmWdata[7:0];
      end
   end

   function automatic logic [31:0] memWord(input int idx);
      return {mem[4*idx], mem[4*idx+1], mem[4*idx+2], mem[4*idx+3]};
   endfunction

   // One comparison: count it, pass or report.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      assert (observed === expected) numPassed++;
      else begin
         numFailed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one request and watch until its response (bounded). Latency is
   // counted in cycles after the acceptance edge; 0 means no response seen.
   task automatic applyStimulus(input logic wr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int latency, output int writes);
      rdata   = 32'hDEADBEEF;
      err     = 1'bx;
      latency = 0;
      writes  = 0;
      @(negedge clk);
      reqWrite  = wr;
      reqSize   = size;
      reqSigned = sgn;
      reqAddr   = addr;
      reqWdata  = wdata;
      reqValid  = 1'b1;
      @(posedge clk);
      #1 reqValid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (dmWrite) writes++;
         if (respValid) begin
            latency = n;
            rdata   = respRdata;
            err     = respErr;
            break;
         end
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          wrs;
   logic [31:0] snap [0:7];
   logic [31:0] expQ [0:2];
   int          nAcc;
   int          nResp;
   int          busyAccept;
   int          sawResp;

   initial begin
      rstN      = 1'b0;
      reqValid  = 1'b0;
      reqWrite  = 1'b0;
      reqSize   = 2'd0;
      reqSigned = 1'b0;
      reqAddr   = 32'd0;
      reqWdata  = 32'd0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);
      mem[8]  = 8'h80;
      mem[9]  = 8'hFF;
      mem[10] = 8'h12;
      mem[11] = 8'h34;

      // Reset values.
      #3;
      checkOutput("rst_ready", {31'd0, reqReady}, 32'd1);
      checkOutput("rst_resp_valid", {31'd0, respValid}, 32'd0);
      checkOutput("rst_resp_err", {31'd0, respErr}, 32'd0);
      checkOutput("rst_resp_rdata", respRdata, 32'd0);
      checkOutput("rst_dm_addr", dmAddr, 32'd0);
      checkOutput("rst_dm_wdata", dmWdata, 32'd0);
      checkOutput("rst_dm_write", {31'd0, dmWrite}, 32'd0);
      @(negedge clk);
      rstN = 1'b1;

      // Loads from the preloaded word 8 = 80 FF 12 34.
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, rd, er, lat, wrs);
      checkOutput("lw8_data", rd, 32'h80FF1234);
      checkOutput("lw8_err", {31'd0, er}, 32'd0);
      checkOutput("lw8_lat", 32'(lat), 32'd2);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'd8, 32'd0, rd, er, lat, wrs);
      checkOutput("lb8_data", rd, 32'hFFFFFF80);
      applyStimulus(1'b0, 2'd0, 1'b0, 32'd8, 32'd0, rd, er, lat, wrs);
      checkOutput("lbu8_data", rd, 32'h00000080);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'd8, 32'd0, rd, er, lat, wrs);
      checkOutput("lh8_data", rd, 32'hFFFF80FF);
      applyStimulus(1'b0, 2'd1, 1'b0, 32'd10, 32'd0, rd, er, lat, wrs);
      checkOutput("lhu10_data", rd, 32'h00001234);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'd11, 32'd0, rd, er, lat, wrs);
      checkOutput("lb11_data", rd, 32'h00000034);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'd10, 32'd0, rd, er, lat, wrs);
      checkOutput("lh10_data", rd, 32'h00001234);

      // Byte store through read-modify-write.
      applyStimulus(1'b1, 2'd0, 1'b0, 32'd9, 32'hAABBCCDD, rd, er, lat, wrs);
      checkOutput("sb9_lat", 32'(lat), 32'd3);
      checkOutput("sb9_writes", 32'(wrs), 32'd1);
      checkOutput("sb9_rdata", rd, 32'd0);
      checkOutput("sb9_err", {31'd0, er}, 32'd0);
      checkOutput("sb9_word8", memWord(2), 32'h80DD1234);
      checkOutput("sb9_word4", memWord(1), 32'h04050607);
      checkOutput("sb9_word12", memWord(3), 32'h0C0D0E0F);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, rd, er, lat, wrs);
      checkOutput("sb9_lw8", rd, 32'h80DD1234);

      // Halfword store on a freshly restored word 8.
      @(negedge clk);
      mem[9] = 8'hFF;
      applyStimulus(1'b1, 2'd1, 1'b0, 32'd10, 32'h0000BEEF, rd, er, lat, wrs);
      checkOutput("sh10_lat", 32'(lat), 32'd3);
      checkOutput("sh10_word8", memWord(2), 32'h80FFBEEF);

      // Word store and read-back.
      applyStimulus(1'b1, 2'd2, 1'b0, 32'd28, 32'hCAFEF00D, rd, er, lat, wrs);
      checkOutput("sw28_lat", 32'(lat), 32'd2);
      checkOutput("sw28_writes", 32'(wrs), 32'd1);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd28, 32'd0, rd, er, lat, wrs);
      checkOutput("lw28_data", rd, 32'hCAFEF00D);

      // Error cases: no write, memory untouched, response one cycle later.
      for (int i = 0; i < 8; i++) snap[i] = memWord(i);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd6, 32'd0, rd, er, lat, wrs);
      checkOutput("lw6_err", {31'd0, er}, 32'd1);
      checkOutput("lw6_rdata", rd, 32'd0);
      checkOutput("lw6_lat", 32'(lat), 32'd1);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'd3, 32'd0, rd, er, lat, wrs);
      checkOutput("lh3_err", {31'd0, er}, 32'd1);
      checkOutput("lh3_lat", 32'(lat), 32'd1);
      applyStimulus(1'b1, 2'd3, 1'b0, 32'd0, 32'h11111111, rd, er, lat, wrs);
      checkOutput("size3_err", {31'd0, er}, 32'd1);
      checkOutput("size3_writes", 32'(wrs), 32'd0);
      checkOutput("size3_lat", 32'(lat), 32'd1);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd32, 32'd0, rd, er, lat, wrs);
      checkOutput("lw32_err", {31'd0, er}, 32'd1);
      checkOutput("lw32_rdata", rd, 32'd0);
      applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h22222222, rd, er, lat, wrs);
      checkOutput("swFFFC_err", {31'd0, er}, 32'd1);
      checkOutput("swFFFC_writes", 32'(wrs), 32'd0);
      for (int i = 0; i < 8; i++) checkOutput("err_mem_unchanged", memWord(i), snap[i]);

      // Back-to-back loads with req_valid held high.
      expQ[0] = 32'h80FFBEEF;
      expQ[1] = 32'h0000BEEF;
      expQ[2] = 32'hFFFFFFFF;
      nAcc       = 0;
      nResp      = 0;
      busyAccept = 0;
      @(negedge clk);
      reqWrite  = 1'b0;
      reqSize   = 2'd2;
      reqSigned = 1'b0;
      reqAddr   = 32'd8;
      reqValid  = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (respValid) begin
            if (nResp < 3) checkOutput("b2b_resp_data", respRdata, expQ[nResp]);
            nResp++;
         end
         if (reqReady && reqValid) begin
            if (nAcc != nResp) busyAccept++;
            nAcc++;
            @(posedge clk);
            #1;
            if (nAcc == 1) begin
               reqSize = 2'd1;
               reqAddr = 32'd10;
            end else if (nAcc == 2) begin
               reqSize   = 2'd0;
               reqSigned = 1'b1;
               reqAddr   = 32'd9;
            end else begin
               reqValid = 1'b0;
            end
         end
         if (nResp >= 3) break;
      end
      reqValid = 1'b0;
      checkOutput("b2b_accepts", 32'(nAcc), 32'd3);
      checkOutput("b2b_responses", 32'(nResp), 32'd3);
      checkOutput("b2b_busy_accept", 32'(busyAccept), 32'd0);

      // Reset asserted in the WRITE cycle before the falling edge.
      @(negedge clk);
      reqWrite  = 1'b1;
      reqSize   = 2'd2;
      reqSigned = 1'b0;
      reqAddr   = 32'd0;
      reqWdata  = 32'h12345678;
      reqValid  = 1'b1;
      @(posedge clk);
      #1 reqValid = 1'b0;
      #1;
      checkOutput("rstw_write_before", {31'd0, dmWrite}, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("rstw_write_after", {31'd0, dmWrite}, 32'd0);
      checkOutput("rstw_ready", {31'd0, reqReady}, 32'd1);
      @(negedge clk);
      rstN = 1'b1;
      sawResp = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (respValid) sawResp++;
      end
      checkOutput("rstw_no_resp", 32'(sawResp), 32'd0);
      checkOutput("rstw_word0", memWord(0), 32'h00010203);
      checkOutput("rstw_ready_idle", {31'd0, reqReady}, 32'd1);

      $display("%0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
